// File: rtl/vga_colorizer_pkg.sv
// Shared palette layout helpers and default colours for the palette colorizer.
// Default colours are 12-bit RGB (4 bits per channel), R in the MSBs.
package vga_colorizer_pkg;

  localparam logic [11:0] DEF_GREY     = 12'hBBB;
  localparam logic [11:0] DEF_BLACK    = 12'h000;
  localparam logic [11:0] DEF_ORANGE   = 12'hF51;
  localparam logic [11:0] DEF_WHITE    = 12'hFFF;
  localparam logic [11:0] DEF_RED      = 12'hF00;
  localparam logic [11:0] DEF_EGGSHELL = 12'hFFE;

  // World codes occupy the bottom of the palette, then one block per icon layer.
  function automatic int pal_size(input int world_w, input int icon_w, input int n_icons);
    return (1 << world_w) + n_icons * (1 << icon_w);
  endfunction

  function automatic int pal_aw(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

  function automatic int pal_index(input int world_w, input int icon_w,
                                   input int layer, input int code);
    return (1 << world_w) + layer * (1 << icon_w) + code;
  endfunction

  function automatic logic [11:0] def_rgb12(input int world_w, input int icon_w,
                                            input int n_icons, input int idx);
    int base;
    int code;
    base = 1 << world_w;
    code = idx - base;
    if (idx < base) begin
      case (idx)
        0:       return DEF_GREY;
        1:       return DEF_BLACK;
        2:       return DEF_ORANGE;
        3:       return DEF_WHITE;
        default: return 12'h000;
      endcase
    end
    if (n_icons > 0 && code < (1 << icon_w)) begin
      case (code)
        1:       return DEF_BLACK;
        2:       return DEF_RED;
        3:       return DEF_EGGSHELL;
        default: return 12'h000;
      endcase
    end
    return 12'h000;
  endfunction

endpackage

// File: rtl/vga_palette_regfile.sv
// Palette register file: reset-to-defaults, one write port, registered read-before-write port.
// Read data appears one clock after rd_addr; rd_blank forces the registered output to zero.
module vga_palette_regfile
  import vga_colorizer_pkg::*;
#(
  parameter int COLOR_W = 4,
  parameter int WORLD_W = 2,
  parameter int ICON_W  = 2,
  parameter int N_ICONS = 2,
  localparam int P  = pal_size(WORLD_W, ICON_W, N_ICONS),
  localparam int AW = pal_aw(P),
  localparam int DW = 3 * COLOR_W
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  input  logic          rd_blank,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [P];
  logic [DW-1:0] mem_d [P];
  logic [DW-1:0] rd_data_q;
  logic [DW-1:0] rd_data_d;

  // Defaults only make sense for 4-bit channels; other widths start black.
  function automatic logic [DW-1:0] reset_value(input int idx);
    if (COLOR_W == 4) return DW'(def_rgb12(WORLD_W, ICON_W, N_ICONS, idx));
    return '0;
  endfunction

  always_comb begin
    mem_d = mem_q;
    if (wr_en && ({1'b0, wr_addr} < (AW+1)'(P))) mem_d[wr_addr] = wr_data;
    rd_data_d = rd_blank ? '0 : mem_q[rd_addr];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < P; i++) mem_q[i] <= reset_value(i);
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/vga_palette_colorizer.sv
// Resolves world/icon layers to a palette index, then looks up colour; 2-clock latency for
// colour and syncs alike. No backpressure: one pixel per clock, palette writable every clock.
module vga_palette_colorizer
  import vga_colorizer_pkg::*;
#(
  parameter int COLOR_W      = 4,
  parameter int WORLD_W      = 2,
  parameter int ICON_W       = 2,
  parameter int N_ICONS      = 2,
  parameter int BLINK_FRAMES = 16,
  localparam int P  = pal_size(WORLD_W, ICON_W, N_ICONS),
  localparam int AW = pal_aw(P)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        video_on,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  input  logic [WORLD_W-1:0]          world_pixel,
  input  logic [N_ICONS*ICON_W-1:0]   icon,
  input  logic [N_ICONS-1:0]          blink_en,
  input  logic                        pal_we,
  input  logic [AW-1:0]               pal_addr,
  input  logic [3*COLOR_W-1:0]        pal_wdata,
  output logic [3*COLOR_W-1:0]        VGA,
  output logic                        video_on_out,
  output logic                        hsync_out,
  output logic                        vsync_out
);

  localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FCW-1:0] FC_LAST = FCW'(BLINK_FRAMES - 1);

  logic           vsync_prev_q, vsync_prev_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic           blink_phase_q, blink_phase_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic           von1_q, von1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic           von2_q, von2_d, hs2_q, hs2_d, vs2_q, vs2_d;
  logic           vsync_rise;

  always_comb begin
    vsync_prev_d  = vsync_in;
    vsync_rise    = vsync_in & ~vsync_prev_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (vsync_rise) begin
      if (frame_cnt_q == FC_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    // Walk from lowest to highest priority so layer 0 overrides last.
    idx_d = AW'(world_pixel);
    for (int k = N_ICONS - 1; k >= 0; k--) begin
      if (icon[k*ICON_W +: ICON_W] != '0 && !(blink_en[k] && blink_phase_q))
        idx_d = AW'(pal_index(WORLD_W, ICON_W, k, int'(icon[k*ICON_W +: ICON_W])));
    end

    von1_d = video_on;
    hs1_d  = hsync_in;
    vs1_d  = vsync_in;
    von2_d = von1_q;
    hs2_d  = hs1_q;
    vs2_d  = vs1_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vsync_prev_q  <= 1'b0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      idx_q         <= '0;
      von1_q        <= 1'b0;
      hs1_q         <= 1'b0;
      vs1_q         <= 1'b0;
      von2_q        <= 1'b0;
      hs2_q         <= 1'b0;
      vs2_q         <= 1'b0;
    end else begin
      vsync_prev_q  <= vsync_prev_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      idx_q         <= idx_d;
      von1_q        <= von1_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      von2_q        <= von2_d;
      hs2_q         <= hs2_d;
      vs2_q         <= vs2_d;
    end
  end

  // The regfile's read register is the second pipeline stage for colour.
  vga_palette_regfile #(
    .COLOR_W (COLOR_W),
    .WORLD_W (WORLD_W),
    .ICON_W  (ICON_W),
    .N_ICONS (N_ICONS)
  ) u_palette (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (pal_we),
    .wr_addr  (pal_addr),
    .wr_data  (pal_wdata),
    .rd_addr  (idx_q),
    .rd_blank (~von1_q),
    .rd_data  (VGA)
  );

  assign video_on_out = von2_q;
  assign hsync_out    = hs2_q;
  assign vsync_out    = vs2_q;

endmodule

// File: tb/tb_vga_palette_colorizer.sv
// Scoreboard bench: each driven pixel queues its expected outputs two clocks ahead,
// a negedge monitor pops and compares them.
module tb_vga_palette_colorizer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        video_on = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [1:0]  world_pixel = 2'd0;
  logic [3:0]  icon = 4'h0;
  logic [1:0]  blink_en = 2'b00;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_addr = 4'd0;
  logic [11:0] pal_wdata = 12'h000;
  logic [11:0] VGA;
  logic        video_on_out, hsync_out, vsync_out;

  typedef struct {
    int          due;
    logic [11:0] vga;
    logic        von;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  vga_palette_colorizer #(.BLINK_FRAMES(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .video_on     (video_on),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .world_pixel  (world_pixel),
    .icon         (icon),
    .blink_en     (blink_en),
    .pal_we       (pal_we),
    .pal_addr     (pal_addr),
    .pal_wdata    (pal_wdata),
    .VGA          (VGA),
    .video_on_out (video_on_out),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_sample: due cycle %0d, now %0d", mon_e.due, cyc);
      end else begin
        chk("vga", VGA, mon_e.vga);
        chk("video_on_out", {11'b0, video_on_out}, {11'b0, mon_e.von});
        chk("hsync_out", {11'b0, hsync_out}, {11'b0, mon_e.hs});
        chk("vsync_out", {11'b0, vsync_out}, {11'b0, mon_e.vs});
      end
    end
  end

  // Called just after a rising edge; inputs are sampled at the next edge.
  task automatic pixw(input logic von, input logic hs, input logic vs,
                      input logic [1:0] w, input logic [3:0] ic,
                      input logic we, input logic [3:0] wa, input logic [11:0] wd,
                      input logic [11:0] exp_vga);
    exp_t e;
    video_on = von; hsync_in = hs; vsync_in = vs;
    world_pixel = w; icon = ic;
    pal_we = we; pal_addr = wa; pal_wdata = wd;
    e.due = cyc + 2;
    e.vga = von ? exp_vga : 12'h000;
    e.von = von; e.hs = hs; e.vs = vs;
    sb.push_back(e);
    @(posedge clock);
    #1;
    pal_we = 1'b0;
  endtask

  task automatic pix(input logic von, input logic hs, input logic vs,
                     input logic [1:0] w, input logic [3:0] ic, input logic [11:0] exp_vga);
    pixw(von, hs, vs, w, ic, 1'b0, 4'd0, 12'h000, exp_vga);
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_vga", VGA, 12'h000);
    chk("reset_von", {11'b0, video_on_out}, 12'h000);
    chk("reset_hs", {11'b0, hsync_out}, 12'h000);
    chk("reset_vs", {11'b0, vsync_out}, 12'h000);
    reset = 1'b0;

    // Resolution and priority with default palette
    pix(1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 12'hF51);
    pix(1'b1, 1'b0, 1'b0, 2'd0, 4'b1110, 12'hF00);
    pix(1'b1, 1'b0, 1'b0, 2'd0, 4'b1100, 12'h000);
    pix(1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 12'hFFF);
    pix(1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 12'hBBB);
    pix(1'b1, 1'b0, 1'b0, 2'd1, 4'b0011, 12'hFFE);
    pix(1'b1, 1'b0, 1'b0, 2'd3, 4'b0001, 12'h000);
    pix(1'b1, 1'b0, 1'b0, 2'd3, 4'b0100, 12'h000);
    pix(1'b0, 1'b0, 1'b0, 2'd2, 4'b0010, 12'h000);
    pix(1'b1, 1'b1, 1'b0, 2'd3, 4'b0000, 12'hFFF);
    pix(1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 12'hF51);

    // Read/write collision on index 0: old value, then new
    pix (1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 12'hBBB);
    pixw(1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 4'd0, 12'h123, 12'h123);
    pix (1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 12'h123);

    // Out-of-range writes, then back-to-back writes to layer-1 entries
    pixw(1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b1, 4'd12, 12'hABC, 12'h000);
    pixw(1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b1, 4'd15, 12'hABC, 12'h000);
    pixw(1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1, 4'd9, 12'h5A5, 12'hF51);
    pixw(1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1, 4'd10, 12'h0A0, 12'hF51);
    pix(1'b1, 1'b0, 1'b0, 2'd0, 4'b0100, 12'h5A5);
    pix(1'b1, 1'b0, 1'b0, 2'd0, 4'b1000, 12'h0A0);
    pix(1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 12'h123);
    pix(1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 12'hFFF);
    pix(1'b1, 1'b0, 1'b0, 2'd0, 4'b0010, 12'hF00);
    pix(1'b1, 1'b0, 1'b0, 2'd0, 4'b1100, 12'h000);

    // Blink on layer 0 with two frames per half-period
    blink_en = 2'b01;
    pix(1'b1, 1'b0, 1'b0, 2'd3, 4'b0001, 12'h000);
    pix(1'b1, 1'b0, 1'b1, 2'd3, 4'b0001, 12'h000);
    pix(1'b1, 1'b0, 1'b0, 2'd3, 4'b0001, 12'h000);
    pix(1'b1, 1'b0, 1'b1, 2'd3, 4'b0001, 12'h000);
    pix(1'b1, 1'b0, 1'b0, 2'd3, 4'b0001, 12'hFFF);
    pix(1'b1, 1'b0, 1'b0, 2'd3, 4'b0001, 12'hFFF);
    pix(1'b1, 1'b0, 1'b0, 2'd3, 4'b0101, 12'h5A5);
    pix(1'b1, 1'b0, 1'b1, 2'd3, 4'b0001, 12'hFFF);
    pix(1'b1, 1'b0, 1'b0, 2'd3, 4'b0001, 12'hFFF);
    pix(1'b1, 1'b0, 1'b1, 2'd3, 4'b0001, 12'hFFF);
    pix(1'b1, 1'b0, 1'b0, 2'd3, 4'b0001, 12'h000);
    pix(1'b1, 1'b0, 1'b0, 2'd3, 4'b0001, 12'h000);
    blink_en = 2'b00;

    // Reset mid-line with the pipeline full
    pix(1'b1, 1'b1, 1'b0, 2'd3, 4'b0000, 12'hFFF);
    pix(1'b1, 1'b1, 1'b0, 2'd3, 4'b0000, 12'hFFF);
    pix(1'b1, 1'b1, 1'b0, 2'd3, 4'b0000, 12'hFFF);
    #1 reset = 1'b1;
    sb.delete();
    #1;
    chk("midreset_vga", VGA, 12'h000);
    chk("midreset_von", {11'b0, video_on_out}, 12'h000);
    chk("midreset_hs", {11'b0, hsync_out}, 12'h000);
    chk("midreset_vs", {11'b0, vsync_out}, 12'h000);
    @(posedge clock);
    #1 reset = 1'b0;
    pix(1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 12'hBBB);
    pix(1'b1, 1'b0, 1'b0, 2'd0, 4'b0100, 12'h000);
    pix(1'b1, 1'b0, 1'b0, 2'd0, 4'b0010, 12'hF00);
    pix(1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 12'h000);
    pix(1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 12'h000);

    repeat (3) @(posedge clock);
    #1;
    chk("drain", 12'(sb.size()), 12'h000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
